// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl
//   Per-ghost behaviour controller. It sequences the SCATTER/CHASE wave
//   schedule and handles the frightened (FRIGHT) and returning-to-pen (EATEN)
//   modes. It also picks the steering target for the direction logic and
//   paces ghost movement with a per-mode frame divider.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   frame_tick            : one-cycle pulse per video frame
//   power_pellet          : one-cycle pulse, Pac-Man ate a power pellet
//   ghost_eaten           : one-cycle pulse, Pac-Man caught this ghost
//   ghost_home            : level, ghost is inside the pen
//   xPacLoc, yPacLoc      : Pac-Man position
//   mode                  : 00 SCATTER, 01 CHASE, 10 FRIGHT, 11 EATEN
//   target_x, target_y    : steering target
//   move_en               : one-cycle step enable
//   reverse               : one-cycle pulse, ghost must turn around
//   flash                 : frightened mode is about to end
//
// state   | meaning
// SCATTER | head for the home corner, base timer running
// CHASE   | head for Pac-Man, base timer running (saturates after wave 4)
// FRIGHT  | wander pseudo-randomly, base timer frozen
// EATEN   | eyes return to the pen, base timer frozen
module ghost_mode_ctrl #(
  parameter int          SCATTER_FRAMES = 420,
  parameter int          CHASE_FRAMES   = 1200,
  parameter int          FRIGHT_FRAMES  = 360,
  parameter int          FLASH_FRAMES   = 120,
  parameter int          NORM_DIV       = 2,
  parameter int          FRIGHT_DIV     = 4,
  parameter int          EATEN_DIV      = 1,
  parameter logic [10:0] CORNER_X       = 11'd0,
  parameter logic [10:0] CORNER_Y       = 11'd0,
  parameter logic [10:0] HOME_X         = 11'd320,
  parameter logic [10:0] HOME_Y         = 11'd240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        power_pellet,
  input  logic        ghost_eaten,
  input  logic        ghost_home,
  input  logic [10:0] xPacLoc,
  input  logic [10:0] yPacLoc,
  output logic [1:0]  mode,
  output logic [10:0] target_x,
  output logic [10:0] target_y,
  output logic        move_en,
  output logic        reverse,
  output logic        flash
);

  localparam logic [1:0] ST_SCATTER = 2'b00;
  localparam logic [1:0] ST_CHASE   = 2'b01;
  localparam logic [1:0] ST_FRIGHT  = 2'b10;
  localparam logic [1:0] ST_EATEN   = 2'b11;

  localparam int TW = 16;
  localparam int DW = 8;

  localparam logic [TW-1:0] SC_LAST = TW'(SCATTER_FRAMES - 1);
  localparam logic [TW-1:0] CH_LAST = TW'(CHASE_FRAMES - 1);
  localparam logic [TW-1:0] FR_LAST = TW'(FRIGHT_FRAMES - 1);
  // A flash window at least as long as FRIGHT collapses to "flash from timer 0".
  localparam int            FL_START_I = (FLASH_FRAMES >= FRIGHT_FRAMES) ? 0
                                         : (FRIGHT_FRAMES - FLASH_FRAMES);
  localparam logic [TW-1:0] FL_START = TW'(FL_START_I);

  localparam logic [DW-1:0] NORM_LAST   = DW'(NORM_DIV - 1);
  localparam logic [DW-1:0] FRIGHT_LAST = DW'(FRIGHT_DIV - 1);
  localparam logic [DW-1:0] EATEN_LAST  = DW'(EATEN_DIV - 1);

  logic [1:0]    r_mode;
  logic          r_base;      // 0 = SCATTER, 1 = CHASE
  logic [TW-1:0] r_btmr;
  logic [2:0]    r_wave;
  logic [TW-1:0] r_ftmr;
  logic [DW-1:0] r_div;
  logic [15:0]   r_lfsr;
  logic [10:0]   r_tx;
  logic [10:0]   r_ty;
  logic          r_move_en;
  logic          r_reverse;
  logic          r_flash;

  logic [1:0]    w_mode_nxt;
  logic          w_base_nxt;
  logic [TW-1:0] w_btmr_nxt;
  logic [2:0]    w_wave_nxt;
  logic [TW-1:0] w_ftmr_nxt;
  logic          w_rev_nxt;
  logic [DW-1:0] w_div_last;
  logic [DW-1:0] w_div_nxt;
  logic          w_mv_nxt;
  logic          w_flash_nxt;
  logic [15:0]   w_lfsr_nxt;
  logic [10:0]   w_tx_nxt;
  logic [10:0]   w_ty_nxt;

  // Mode sequencing. Pellet beats base-timer expiry (timer not advanced);
  // ghost_eaten beats both pellet restart and fright expiry.
  always_comb begin
    w_mode_nxt = r_mode;
    w_base_nxt = r_base;
    w_btmr_nxt = r_btmr;
    w_wave_nxt = r_wave;
    w_ftmr_nxt = r_ftmr;
    w_rev_nxt  = 1'b0;
    case (r_mode)
      ST_SCATTER, ST_CHASE: begin
        if (power_pellet) begin
          w_mode_nxt = ST_FRIGHT;
          w_base_nxt = r_mode[0];
          w_ftmr_nxt = '0;
          w_rev_nxt  = 1'b1;
        end else if (frame_tick) begin
          if (r_mode == ST_SCATTER) begin
            if (r_btmr == SC_LAST) begin
              w_mode_nxt = ST_CHASE;
              w_btmr_nxt = '0;
              w_wave_nxt = r_wave + 3'd1;
              w_rev_nxt  = 1'b1;
            end else begin
              w_btmr_nxt = r_btmr + 1'b1;
            end
          end else if (r_btmr == CH_LAST) begin
            // After the fourth wave CHASE is permanent; timer holds at its last value.
            if (r_wave < 3'd4) begin
              w_mode_nxt = ST_SCATTER;
              w_btmr_nxt = '0;
              w_rev_nxt  = 1'b1;
            end
          end else begin
            w_btmr_nxt = r_btmr + 1'b1;
          end
        end
      end
      ST_FRIGHT: begin
        if (ghost_eaten) begin
          w_mode_nxt = ST_EATEN;
        end else if (power_pellet) begin
          w_ftmr_nxt = '0;
        end else if (frame_tick) begin
          if (r_ftmr == FR_LAST) begin
            w_mode_nxt = {1'b0, r_base};
          end else begin
            w_ftmr_nxt = r_ftmr + 1'b1;
          end
        end
      end
      default: begin
        if (ghost_home) begin
          w_mode_nxt = {1'b0, r_base};
        end
      end
    endcase
  end

  // Step divider follows the mode being entered; a mode change restarts it.
  always_comb begin
    case (w_mode_nxt)
      ST_FRIGHT: w_div_last = FRIGHT_LAST;
      ST_EATEN:  w_div_last = EATEN_LAST;
      default:   w_div_last = NORM_LAST;
    endcase
    w_div_nxt = r_div;
    w_mv_nxt  = 1'b0;
    if (w_mode_nxt != r_mode) begin
      w_div_nxt = '0;
    end else if (frame_tick) begin
      w_div_nxt = (r_div == w_div_last) ? '0 : r_div + 1'b1;
      w_mv_nxt  = (w_div_nxt == w_div_last);
    end
  end

  assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_flash_nxt = (w_mode_nxt == ST_FRIGHT) && (w_ftmr_nxt >= FL_START);

  // Target is chosen from the mode being entered so it changes on the same edge as mode.
  always_comb begin
    case (w_mode_nxt)
      ST_CHASE: begin
        w_tx_nxt = xPacLoc;
        w_ty_nxt = yPacLoc;
      end
      ST_FRIGHT: begin
        w_tx_nxt = w_lfsr_nxt[10:0];
        w_ty_nxt = w_lfsr_nxt[15:5];
      end
      ST_EATEN: begin
        w_tx_nxt = HOME_X;
        w_ty_nxt = HOME_Y;
      end
      default: begin
        w_tx_nxt = CORNER_X;
        w_ty_nxt = CORNER_Y;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= ST_SCATTER;
      r_base    <= 1'b0;
      r_btmr    <= '0;
      r_wave    <= '0;
      r_ftmr    <= '0;
      r_div     <= '0;
      r_lfsr    <= 16'hACE1;
      r_tx      <= CORNER_X;
      r_ty      <= CORNER_Y;
      r_move_en <= 1'b0;
      r_reverse <= 1'b0;
      r_flash   <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_base    <= w_base_nxt;
      r_btmr    <= w_btmr_nxt;
      r_wave    <= w_wave_nxt;
      r_ftmr    <= w_ftmr_nxt;
      r_div     <= w_div_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_tx      <= w_tx_nxt;
      r_ty      <= w_ty_nxt;
      r_move_en <= w_mv_nxt;
      r_reverse <= w_rev_nxt;
      r_flash   <= w_flash_nxt;
    end
  end

  assign mode     = r_mode;
  assign target_x = r_tx;
  assign target_y = r_ty;
  assign move_en  = r_move_en;
  assign reverse  = r_reverse;
  assign flash    = r_flash;

endmodule
